// File: rtl/prefetch_issue_queue.sv
// Line-granular prefetch FIFO that drops duplicates against queued entries and recently issued lines.
// Issue 1 cycle after accept into empty queue; pf_ready_o = ~full (no bypass). Optional PF_ISSUE_STATS_EN adds counters.
module prefetch_issue_queue #(
  parameter int WIDTH        = 64,
  parameter int DEPTH        = 8,
  parameter int LOGLINE      = 6,
  parameter int HIST_ENTRIES = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             pf_address_i,
  input  logic                         pf_valid_i,
  output logic                         pf_ready_o,
  output logic [WIDTH-1:0]             lo_address_o,
  output logic                         lo_valid_o,
  input  logic                         lo_ready_i,
  input  logic                         flush_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
`ifdef PF_ISSUE_STATS_EN
  ,
  output logic [31:0]                  issued_cnt_o,
  output logic [31:0]                  dropped_cnt_o
`endif
);

  localparam int LW = WIDTH - LOGLINE;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int HW = (HIST_ENTRIES > 1) ? $clog2(HIST_ENTRIES) : 1;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_PARTIAL,
    S_FULL
  } occ_e;

  logic [LW-1:0]           r_mem [DEPTH];
  logic [AW:0]             r_wptr;
  logic [AW:0]             r_rptr;
  logic [LW-1:0]           r_hist [HIST_ENTRIES];
  logic [HIST_ENTRIES-1:0] r_hist_vld;
  logic [HW-1:0]           r_hist_ptr;

  occ_e                    w_state;
  logic                    w_empty;
  logic                    w_full;
  logic [CW-1:0]           w_count;
  logic [LW-1:0]           w_line;
  logic [LW-1:0]           w_head;
  logic [DEPTH-1:0]        w_occ;
  logic [DEPTH-1:0]        w_qeq;
  logic [HIST_ENTRIES-1:0] w_heq;
  logic                    w_hit;
  logic                    w_acc;
  logic                    w_deq;
  logic                    w_enq;
  logic                    w_unused_offset;

  assign w_line          = pf_address_i[WIDTH-1:LOGLINE];
  assign w_unused_offset = ^pf_address_i[LOGLINE-1:0];
  assign w_count         = CW'(r_wptr - r_rptr);
  assign w_head          = r_mem[r_rptr[AW-1:0]];

  always_comb begin
    w_state = S_PARTIAL;
    if (r_wptr == r_rptr) begin
      w_state = S_EMPTY;
    end else if (r_wptr[AW-1:0] == r_rptr[AW-1:0]) begin
      w_state = S_FULL;
    end
  end

  assign w_empty = (w_state == S_EMPTY);
  assign w_full  = (w_state == S_FULL);

  // An entry is live when its distance from the read index is below the occupancy.
  for (genvar i = 0; i < DEPTH; i++) begin : g_q
    logic [AW-1:0] w_off;
    assign w_off    = AW'(i) - r_rptr[AW-1:0];
    assign w_occ[i] = ({1'b0, w_off} < w_count);
    assign w_qeq[i] = (r_mem[i] == w_line);
  end

  for (genvar j = 0; j < HIST_ENTRIES; j++) begin : g_h
    assign w_heq[j] = r_hist_vld[j] & (r_hist[j] == w_line);
  end

  assign w_hit = |(w_occ & w_qeq) | (|w_heq);
  assign w_acc = pf_valid_i & ~w_full;
  assign w_deq = ~w_empty & lo_ready_i;
  assign w_enq = w_acc & ~w_hit & ~flush_i;

  assign pf_ready_o   = ~w_full;
  assign lo_valid_o   = ~w_empty;
  assign count_o      = w_count;
  assign lo_address_o = w_empty ? '0 : {w_head, {LOGLINE{1'b0}}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_hist_vld <= '0;
      r_hist_ptr <= '0;
    end else if (flush_i) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_hist_vld <= '0;
      r_hist_ptr <= '0;
    end else begin
      if (w_enq) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_deq) begin
        r_rptr                 <= r_rptr + 1'b1;
        r_hist_vld[r_hist_ptr] <= 1'b1;
        if (r_hist_ptr == HW'(HIST_ENTRIES - 1)) begin
          r_hist_ptr <= '0;
        end else begin
          r_hist_ptr <= r_hist_ptr + 1'b1;
        end
      end
    end
  end

  // Payload storage needs no reset; validity is carried by pointers and r_hist_vld.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem[r_wptr[AW-1:0]] <= w_line;
    end
    if (w_deq && !flush_i) begin
      r_hist[r_hist_ptr] <= w_head;
    end
  end

`ifdef PF_ISSUE_STATS_EN
  logic r_unused_stats;
  logic w_drop_evt;

  assign w_drop_evt = (w_acc & w_hit) | (pf_valid_i & w_full);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_cnt_o   <= '0;
      dropped_cnt_o  <= '0;
      r_unused_stats <= 1'b0;
    end else begin
      r_unused_stats <= 1'b0;
      if (w_deq && (issued_cnt_o != 32'hFFFF_FFFF)) begin
        issued_cnt_o <= issued_cnt_o + 32'd1;
      end
      if (w_drop_evt && (dropped_cnt_o != 32'hFFFF_FFFF)) begin
        dropped_cnt_o <= dropped_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_prefetch_issue_queue.sv
// Bench for prefetch_issue_queue: vector table, directed corner sequences, then random traffic vs a queue model.
module tb_prefetch_issue_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] pf_address_i = '0;
  logic        pf_valid_i = 1'b0;
  logic        pf_ready_o;
  logic [63:0] lo_address_o;
  logic        lo_valid_o;
  logic        lo_ready_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [3:0]  count_o;
`ifdef PF_ISSUE_STATS_EN
  logic [31:0] issued_cnt_o;
  logic [31:0] dropped_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  prefetch_issue_queue dut (
    .clk          (clk),
    .rst          (rst),
    .pf_address_i (pf_address_i),
    .pf_valid_i   (pf_valid_i),
    .pf_ready_o   (pf_ready_o),
    .lo_address_o (lo_address_o),
    .lo_valid_o   (lo_valid_o),
    .lo_ready_i   (lo_ready_i),
    .flush_i      (flush_i),
    .count_o      (count_o)
`ifdef PF_ISSUE_STATS_EN
    ,
    .issued_cnt_o (issued_cnt_o),
    .dropped_cnt_o(dropped_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: queue of lines plus a bounded list of most recently issued lines.
  logic [57:0] mq[$];
  logic [57:0] mh[$];
  longint m_iss = 0;
  longint m_drp = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_step();
    logic [57:0] line;
    logic [57:0] h;
    bit pr, lv, acc, deq, dup;
    line = pf_address_i[63:6];
    pr   = (mq.size() < 8);
    lv   = (mq.size() > 0);
    acc  = pf_valid_i && pr;
    deq  = lv && lo_ready_i;
    dup  = 0;
    if (acc) begin
      foreach (mq[k]) if (mq[k] == line) dup = 1;
      foreach (mh[k]) if (mh[k] == line) dup = 1;
    end
    if (deq) m_iss++;
    if ((acc && dup) || (pf_valid_i && !pr)) m_drp++;
    if (flush_i) begin
      mq.delete();
      mh.delete();
    end else begin
      if (deq) begin
        h = mq.pop_front();
        mh.push_back(h);
        if (mh.size() > 16) void'(mh.pop_front());
      end
      if (acc && !dup) mq.push_back(line);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_valid"}, 64'(lo_valid_o), 64'(mq.size() > 0));
    chk({tag, "_ready"}, 64'(pf_ready_o), 64'(mq.size() < 8));
    chk({tag, "_count"}, 64'(count_o), 64'(mq.size()));
    if (mq.size() > 0) chk({tag, "_addr"}, lo_address_o, {mq[0], 6'b0});
  endtask

  task automatic drive(input bit v, input logic [63:0] a, input bit r, input bit f);
    pf_valid_i   = v;
    pf_address_i = a;
    lo_ready_i   = r;
    flush_i      = f;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  typedef struct {
    logic        v;
    logic [63:0] a;
    logic        rdy;
    logic        fl;
    logic        ev;
    logic [63:0] ea;
    logic        er;
    logic [3:0]  ec;
  } vec_t;

  vec_t vt[10];

  initial begin
    vt[0] = '{1, 64'h1234, 1, 0, 1, 64'h1200, 1, 4'd1};
    vt[1] = '{0, 64'h0,    1, 0, 0, 64'h0,    1, 4'd0};
    vt[2] = '{1, 64'h1000, 0, 0, 1, 64'h1000, 1, 4'd1};
    vt[3] = '{1, 64'h1008, 0, 0, 1, 64'h1000, 1, 4'd1};
    vt[4] = '{1, 64'h1010, 0, 0, 1, 64'h1000, 1, 4'd1};
    vt[5] = '{0, 64'h0,    1, 0, 0, 64'h0,    1, 4'd0};
    vt[6] = '{1, 64'h1000, 0, 0, 0, 64'h0,    1, 4'd0};
    vt[7] = '{1, 64'h1240, 0, 0, 1, 64'h1240, 1, 4'd1};
    vt[8] = '{1, 64'h1234, 0, 0, 1, 64'h1240, 1, 4'd1};
    vt[9] = '{0, 64'h0,    1, 0, 0, 64'h0,    1, 4'd0};

    // Reset state
    #1;
    chk("rst_valid", 64'(lo_valid_o), 64'd0);
    chk("rst_addr", lo_address_o, 64'd0);
    chk("rst_ready", 64'(pf_ready_o), 64'd1);
    chk("rst_count", 64'(count_o), 64'd0);
`ifdef PF_ISSUE_STATS_EN
    chk("rst_issued", 64'(issued_cnt_o), 64'd0);
    chk("rst_dropped", 64'(dropped_cnt_o), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Single request, queue duplicates, history duplicates
    for (int i = 0; i < 10; i++) begin
      drive(vt[i].v, vt[i].a, vt[i].rdy, vt[i].fl);
      step();
      chk($sformatf("vec%0d_valid", i), 64'(lo_valid_o), 64'(vt[i].ev));
      chk($sformatf("vec%0d_ready", i), 64'(pf_ready_o), 64'(vt[i].er));
      chk($sformatf("vec%0d_count", i), 64'(count_o), 64'(vt[i].ec));
      if (vt[i].ev) chk($sformatf("vec%0d_addr", i), lo_address_o, vt[i].ea);
    end

    // Fill then drain
    drive(0, 0, 0, 1); step();
    for (int k = 1; k <= 9; k++) begin
      drive(1, 64'(k) * 64'h40, 0, 0);
      step();
      if (k <= 8) chk($sformatf("fill%0d_count", k), 64'(count_o), 64'(k));
      if (k == 8) chk("fill_full_ready", 64'(pf_ready_o), 64'd0);
    end
    chk("fill_ninth_rejected", 64'(count_o), 64'd8);
    drive(0, 0, 1, 0);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("drain%0d_valid", k), 64'(lo_valid_o), 64'd1);
      chk($sformatf("drain%0d_addr", k), lo_address_o, 64'(k) * 64'h40);
      step();
    end
    chk("drain_count", 64'(count_o), 64'd0);
    chk("drain_valid", 64'(lo_valid_o), 64'd0);

    // Flush with a same-cycle accept
    drive(0, 0, 0, 1); step();
    for (int k = 0; k < 5; k++) begin
      drive(1, 64'h5000 + 64'(k) * 64'h40, 0, 0);
      step();
    end
    chk("flush_pre_count", 64'(count_o), 64'd5);
    drive(1, 64'h3000, 0, 1); step();
    chk("flush_count", 64'(count_o), 64'd0);
    chk("flush_valid", 64'(lo_valid_o), 64'd0);
    drive(1, 64'h3000, 0, 0); step();
    chk("flush_reaccept_count", 64'(count_o), 64'd1);
    chk("flush_reaccept_addr", lo_address_o, 64'h3000);
    drive(0, 0, 1, 0); step();

    // History hit, then eviction after 16 other issues
    drive(0, 0, 0, 1); step();
    drive(1, 64'h2000, 0, 0); step();
    chk("hist_first_count", 64'(count_o), 64'd1);
    drive(0, 0, 1, 0); step();
    chk("hist_issued_count", 64'(count_o), 64'd0);
    drive(1, 64'h2000, 0, 0); step();
    chk("hist_hit_dropped", 64'(count_o), 64'd0);
    for (int k = 0; k < 16; k++) begin
      drive(1, 64'h3000 + 64'(k) * 64'h40, 1, 0);
      step();
    end
    drive(0, 0, 1, 0); step();
    chk("hist_others_drained", 64'(count_o), 64'd0);
    drive(1, 64'h2000, 0, 0); step();
    chk("hist_evicted_count", 64'(count_o), 64'd1);
    chk("hist_evicted_addr", lo_address_o, 64'h2000);
    drive(0, 0, 1, 0); step();

    // Async reset mid-drain
    drive(0, 0, 0, 1); step();
    for (int k = 0; k < 3; k++) begin
      drive(1, 64'h7000 + 64'(k) * 64'h40, 0, 0);
      step();
    end
    drive(0, 0, 1, 0); step();
    chk("pre_reset_count", 64'(count_o), 64'd2);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(lo_valid_o), 64'd0);
    chk("arst_count", 64'(count_o), 64'd0);
    chk("arst_ready", 64'(pf_ready_o), 64'd1);
    chk("arst_addr", lo_address_o, 64'd0);
`ifdef PF_ISSUE_STATS_EN
    chk("arst_issued", 64'(issued_cnt_o), 64'd0);
    chk("arst_dropped", 64'(dropped_cnt_o), 64'd0);
`endif
    mq.delete();
    mh.delete();
    m_iss = 0;
    m_drp = 0;
    drive(0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 64'h7000, 0, 0); step();
    chk("post_reset_accept", 64'(count_o), 64'd1);
    drive(0, 0, 1, 0); step();

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [63:0] a;
      a = (64'($urandom_range(0, 40)) << 6) | 64'($urandom_range(0, 63));
      check_model("rand");
      drive($urandom_range(0, 3) != 0, a,
            (n < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
            $urandom_range(0, 63) == 0);
      step();
    end
    check_model("rand_end");
`ifdef PF_ISSUE_STATS_EN
    chk("stats_issued", 64'(issued_cnt_o), 64'(m_iss));
    chk("stats_dropped", 64'(dropped_cnt_o), 64'(m_drp));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
